lsu_mem_port: RTL and testbench

//  Parametrised load/store unit between the core execute stage and a word-wide data memory.
//  - Accepts one RV load/store per handshake.
//  - Drives byte-lane enables and steers store data onto the correct lanes.
//  - Sign- or zero-extends load data by funct3.
//  - Splits accesses that cross a word boundary into two memory transactions (optional, see CONFIGURATION).

---
 rtl/lsu_mem_port_if.sv | 55 +++++
 rtl/lsu_mem_port.sv | 208 ++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
// Interfaces for lsu_mem_port.
//   lsu_core_if : execute-stage request/response handshake.
//     master = core (drives lsu_valid/we/funct3/addr/wdata)
//     slave  = LSU  (drives lsu_ready/done/rdata/err)
//   lsu_bus_if  : word-wide data memory port.
//     master = LSU    (drives mem_req/we/addr/be/wdata)
//     slave  = memory (drives mem_gnt/rvalid/rdata)
interface lsu_core_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              lsu_valid;
  logic              lsu_ready;
  logic              lsu_we;
  logic [2:0]        lsu_funct3;
  logic [ADDR_W-1:0] lsu_addr;
  logic [XLEN-1:0]   lsu_wdata;
  logic              lsu_done;
  logic [XLEN-1:0]   lsu_rdata;
  logic              lsu_err;

  modport master (
    output lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
    input  lsu_ready, lsu_done, lsu_rdata, lsu_err
  );
  modport slave (
    input  lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
    output lsu_ready, lsu_done, lsu_rdata, lsu_err
  );
endinterface

interface lsu_bus_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit between execute stage and a word-wide data memory.
//   Accepts one load/store per handshake, drives byte enables, lane-steers store
//   data, sign/zero-extends load data, optionally splits word-crossing accesses.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   core  : lsu_core_if.slave  (lsu_valid/ready/we/funct3/addr/wdata/done/rdata/err)
//   mem   : lsu_bus_if.master  (mem_req/gnt/we/addr/be/wdata/rvalid/rdata)
// Build option:
//   LSU_MISALIGN_SPLIT_EN defined   -> word-crossing accesses become two transactions.
//   LSU_MISALIGN_SPLIT_EN undefined -> word-crossing accesses finish with lsu_err=1.
module lsu_mem_port #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input logic       clk,
  input logic       reset,
  lsu_core_if.slave core,
  lsu_bus_if.master mem
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
`ifdef LSU_MISALIGN_SPLIT_EN
    REQ1,
    WAIT1,
`endif
    DONE
  } state_e;

  state_e state_q, state_d;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              split_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [XLEN-1:0]   lo_q;     // part-0 read word, held until part 1 returns
`endif

  // Pick the addressed bytes out of {part1, part0}, then extend from the access size.
  function automatic logic [XLEN-1:0] load_ext(input logic [2*XLEN-1:0] pair,
                                               input logic [OW-1:0]     off,
                                               input logic [2:0]        f3);
    logic [2*XLEN-1:0] s;
    logic [XLEN-1:0]   raw;
    int                sh;
    s   = pair >> (8 * int'(off));
    raw = s[XLEN-1:0];
    sh  = XLEN - (8 << f3[1:0]);
    raw = raw << sh;
    if (f3[2]) return raw >> sh;
    return XLEN'($signed(raw) >>> sh);
  endfunction

  // ---------------- request decode (IDLE, from live inputs) ----------------
  logic [OW-1:0] in_off;
  logic [3:0]    in_size;
  logic          in_legal, in_cross, in_bad, accept;

  always_comb begin
    in_off  = core.lsu_addr[OW-1:0];
    in_size = 4'd1 << core.lsu_funct3[1:0];
    if (core.lsu_we)
      in_legal = !core.lsu_funct3[2] && !(XLEN == 32 && core.lsu_funct3[1:0] == 2'b11);
    else
      in_legal = (core.lsu_funct3 != 3'b111) &&
                 !(XLEN == 32 && (core.lsu_funct3 == 3'b011 || core.lsu_funct3 == 3'b110));
    in_cross = (int'(in_off) + int'(in_size)) > NB;
    in_bad   = !in_legal || (in_cross && !SPLIT_EN);
    accept   = (state_q == IDLE) && core.lsu_valid;
  end

  // ---------------- lane steering from registered request ----------------
  logic [OW-1:0]     off;
  logic [3:0]        size;
  logic [XLEN-1:0]   wd_trim;
  logic [2*XLEN-1:0] lane_wd;   // low half = part 0 lanes, high half = part 1 lanes
  logic [2*NB-1:0]   lane_be;
  logic [ADDR_W-1:0] word0, word1;
  int                wsh;

  always_comb begin
    off     = addr_q[OW-1:0];
    size    = 4'd1 << f3_q[1:0];
    wsh     = XLEN - 8 * int'(size);
    // Drop rs2 bits above the access size so unused lanes carry zero.
    wd_trim = (wdata_q << wsh) >> wsh;
    lane_wd = {{XLEN{1'b0}}, wd_trim} << (8 * int'(off));
    lane_be = (2*NB)'((32'd1 << size) - 32'd1) << off;
    word0   = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
    word1   = word0 + ADDR_W'(NB);   // wraps at top of address space
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (core.lsu_valid) state_d = in_bad ? DONE : REQ0;
      REQ0:  if (mem.mem_gnt) state_d = WAIT0;
`ifdef LSU_MISALIGN_SPLIT_EN
      WAIT0: if (mem.mem_rvalid) state_d = split_q ? REQ1 : DONE;
      REQ1:  if (mem.mem_gnt) state_d = WAIT1;
      WAIT1: if (mem.mem_rvalid) state_d = DONE;
`else
      WAIT0: if (mem.mem_rvalid) state_d = DONE;
`endif
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_be    = '0;
    mem.mem_wdata = '0;
    case (state_q)
      REQ0: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_addr  = word0;
        mem.mem_be    = lane_be[NB-1:0];
        mem.mem_wdata = we_q ? lane_wd[XLEN-1:0] : '0;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      REQ1: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_addr  = word1;
        mem.mem_be    = lane_be[2*NB-1:NB];
        mem.mem_wdata = we_q ? lane_wd[2*XLEN-1:XLEN] : '0;
      end
`endif
      default: ;
    endcase
    core.lsu_ready = (state_q == IDLE);
    core.lsu_done  = (state_q == DONE);
    core.lsu_rdata = rdata_q;
    core.lsu_err   = err_q;
  end

  // ---------------- request capture / result ----------------
  // rdata/err only change on the way into DONE, so they hold the previous
  // result while the next access is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      split_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_q    <= '0;
`endif
    end else begin
      if (accept) begin
        we_q    <= core.lsu_we;
        f3_q    <= core.lsu_funct3;
        addr_q  <= core.lsu_addr;
        wdata_q <= core.lsu_wdata;
        split_q <= in_cross;
        if (in_bad) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state_q == WAIT0 && mem.mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
        lo_q <= mem.mem_rdata;
`endif
        if (!split_q) begin
          rdata_q <= we_q ? '0 : load_ext({{XLEN{1'b0}}, mem.mem_rdata}, off, f3_q);
          err_q   <= 1'b0;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state_q == WAIT1 && mem.mem_rvalid) begin
        rdata_q <= we_q ? '0 : load_ext({mem.mem_rdata, lo_q}, off, f3_q);
        err_q   <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port (XLEN=32): expected memory requests and
// completions are queued at issue time; a monitor pops and compares on every
// grant and every lsu_done.
module tb_lsu_mem_port;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_core_if #(.XLEN(32), .ADDR_W(32)) core();
  lsu_bus_if  #(.XLEN(32), .ADDR_W(32)) bus();

  lsu_mem_port #(.XLEN(32), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .core  (core),
    .mem   (bus)
  );

  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we; } req_t;
  typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_tgt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int   stall_cfg = 0, rv_cfg = 0;
  int   req_age = 0, rv_wait = 0, gnt_cnt = 0;
  logic rv_pend = 1'b0;
  logic [31:0] rv_word = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'habcde4ef;
    if (a == 32'h14) return 32'h11223344;
    return a ^ 32'h5a5a5a5a;
  endfunction

  assign bus.mem_gnt    = bus.mem_req && (req_age >= stall_cfg);
  assign bus.mem_rvalid = rv_pend && (rv_wait >= rv_cfg);
  assign bus.mem_rdata  = rv_word;

  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_gnt) req_age <= req_age + 1;
    else                             req_age <= 0;
    if (bus.mem_req && bus.mem_gnt) begin
      rv_pend <= 1'b1;
      rv_wait <= 0;
      rv_word <= mem_word(bus.mem_addr);
      gnt_cnt <= gnt_cnt + 1;
    end else if (rv_pend) begin
      if (bus.mem_rvalid) rv_pend <= 1'b0;
      else                rv_wait <= rv_wait + 1;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    req_t r, snap;
    rsp_t p;
    bit   stalled = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !bus.mem_gnt) begin
        if (stalled) begin
          chk("stall_addr",  bus.mem_addr,  snap.addr);
          chk("stall_be",    bus.mem_be,    snap.be);
          chk("stall_wdata", bus.mem_wdata, snap.wdata);
          chk("stall_we",    bus.mem_we,    snap.we);
        end
        snap = '{bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.mem_we};
        stalled = 1;
      end else stalled = 0;
      if (bus.mem_req && bus.mem_gnt) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_req addr=%h", bus.mem_addr);
        end else begin
          r = exp_req.pop_front();
          chk("req_addr",  bus.mem_addr,  r.addr);
          chk("req_be",    bus.mem_be,    r.be);
          chk("req_wdata", bus.mem_wdata, r.wdata);
          chk("req_we",    bus.mem_we,    r.we);
        end
      end
      if (core.lsu_done) begin
        done_cnt++;
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done rdata=%h", core.lsu_rdata);
        end else begin
          p = exp_rsp.pop_front();
          chk("rdata",   core.lsu_rdata, p.rdata);
          chk("err",     core.lsu_err,   p.err);
          chk("latency", cyc,            p.cyc);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_req(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input logic we);
    exp_req.push_back('{a, be, wd, we});
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input bit exp_on, input logic [31:0] er, input logic ee, input int lat);
    rsp_t p;
    @(negedge clk);
    chk("ready_at_issue", core.lsu_ready, 1);
    core.lsu_valid  = 1'b1;
    core.lsu_we     = we;
    core.lsu_funct3 = f3;
    core.lsu_addr   = a;
    core.lsu_wdata  = wd;
    if (exp_on) begin
      p = '{er, ee, cyc + lat};
      exp_rsp.push_back(p);
    end
    done_tgt = done_cnt + 1;
    @(negedge clk);
    core.lsu_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done_cnt >= done_tgt) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL done_timeout got=%0d exp=%0d", done_cnt, done_tgt);
    end
  endtask

  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee, input int lat);
    issue(we, f3, a, wd, 1, er, ee, lat);
    wait_done();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // ---------------- directed tests ----------------
  initial begin
    int g0, dc;
    bit ok;
    core.lsu_valid = 0; core.lsu_we = 0; core.lsu_funct3 = 0; core.lsu_addr = 0; core.lsu_wdata = 0;
    #3;
    chk("rst_ready", core.lsu_ready, 1);
    chk("rst_done",  core.lsu_done,  0);
    chk("rst_rdata", core.lsu_rdata, 0);
    chk("rst_err",   core.lsu_err,   0);
    chk("rst_req",   bus.mem_req,    0);
    chk("rst_be",    bus.mem_be,     0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: SW
    push_req(32'h20, 4'b1111, 32'habcde4ef, 1);
    run(1, 3'b010, 32'h20, 32'habcde4ef, 32'h0, 0, 3);

    // 2: sub-word loads at 0x10
    push_req(32'h10, 4'b0011, 0, 0); run(0, 3'b001, 32'h10, 0, 32'hffffe4ef, 0, 3);
    push_req(32'h10, 4'b0011, 0, 0); run(0, 3'b101, 32'h10, 0, 32'h0000e4ef, 0, 3);
    push_req(32'h10, 4'b0001, 0, 0); run(0, 3'b000, 32'h10, 0, 32'hffffffef, 0, 3);
    push_req(32'h10, 4'b0001, 0, 0); run(0, 3'b100, 32'h10, 0, 32'h000000ef, 0, 3);

    // 3: intra-word offsets
    push_req(32'h10, 4'b0100, 32'h000f0000, 1); run(1, 3'b000, 32'h12, 32'h0000000f, 32'h0, 0, 3);
    push_req(32'h10, 4'b0110, 0, 0);            run(0, 3'b001, 32'h11, 0, 32'hffffcde4, 0, 3);

    // 4: word-crossing accesses
`ifdef LSU_MISALIGN_SPLIT_EN
    push_req(32'h10, 4'b1110, 0, 0); push_req(32'h14, 4'b0001, 0, 0);
    run(0, 3'b010, 32'h11, 0, 32'h44abcde4, 0, 5);
    push_req(32'h10, 4'b1000, 32'hef000000, 1); push_req(32'h14, 4'b0001, 32'h000000be, 1);
    run(1, 3'b001, 32'h13, 32'h0000beef, 32'h0, 0, 5);
    push_req(32'hfffffffc, 4'b1000, 0, 0); push_req(32'h0, 4'b0111, 0, 0);
    run(0, 3'b010, 32'hffffffff, 0, 32'h5a5a5aa5, 0, 5);
`else
    g0 = gnt_cnt;
    run(0, 3'b010, 32'h11, 0, 32'h0, 1, 1);
    run(1, 3'b001, 32'h13, 32'h0000beef, 32'h0, 1, 1);
    chk("cross_no_req", gnt_cnt, g0);
`endif

    // 5: back-pressure (4 cycles no gnt, rvalid 3 cycles late) and illegal funct3
    stall_cfg = 4; rv_cfg = 3;
    push_req(32'h24, 4'b1111, 32'h11223344, 1);
    run(1, 3'b010, 32'h24, 32'h11223344, 32'h0, 0, 10);
    stall_cfg = 0; rv_cfg = 0;
    g0 = gnt_cnt;
    run(0, 3'b011, 32'h10, 0, 32'h0, 1, 1);
    run(1, 3'b011, 32'h10, 0, 32'h0, 1, 1);
    run(0, 3'b111, 32'h10, 0, 32'h0, 1, 1);
    chk("illegal_no_req", gnt_cnt, g0);

    // 6: reset in WAIT0, stale rvalid afterwards
    push_req(32'h14, 4'b1111, 0, 0); run(0, 3'b010, 32'h14, 0, 32'h11223344, 0, 3);
    rv_cfg = 6;
    push_req(32'h10, 4'b1111, 0, 0);
    g0 = gnt_cnt + 1;
    issue(0, 3'b010, 32'h10, 0, 0, 0, 0, 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (gnt_cnt >= g0) begin ok = 1; break; end
    end
    chk("abort_granted", ok, 1);
    chk("wait0_busy", core.lsu_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", core.lsu_ready, 1);
    chk("mid_rst_done",  core.lsu_done,  0);
    chk("mid_rst_rdata", core.lsu_rdata, 0);
    chk("mid_rst_err",   core.lsu_err,   0);
    chk("mid_rst_req",   bus.mem_req,    0);
    chk("mid_rst_we",    bus.mem_we,     0);
    chk("mid_rst_addr",  bus.mem_addr,   0);
    chk("mid_rst_be",    bus.mem_be,     0);
    chk("mid_rst_wdata", bus.mem_wdata,  0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = done_cnt;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!rv_pend) begin ok = 1; break; end
    end
    chk("stale_rvalid_seen", ok, 1);
    @(negedge clk);
    chk("stale_no_done", done_cnt, dc);
    rv_cfg = 0;
    push_req(32'h10, 4'b1111, 0, 0);
    run(0, 3'b010, 32'h10, 0, 32'habcde4ef, 0, 3);

    repeat (3) @(negedge clk);
    chk("req_queue_empty", exp_req.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
